// File: rtl/gate_array_pipe_if.sv
// +----------------------------------------------------------------------------+
// | gate_array_pipe_if                                                         |
// | Operand-side and result-side valid/ready bundle for gate_array_pipe.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gate_array_pipe_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2:0]              mode;
   logic [NUM_IN*WIDTH-1:0] a_bus;
   logic [WIDTH-1:0]        y;
   logic                    out_valid;
   logic                    out_ready;
   logic                    zero_flag;
   logic                    err;

   modport master (
      output in_valid, mode, a_bus, out_ready,
      input  in_ready, y, out_valid, zero_flag, err
   );

   modport slave (
      input  in_valid, mode, a_bus, out_ready,
      output in_ready, y, out_valid, zero_flag, err
   );
endinterface

`default_nettype wire

// File: rtl/gate_array_pipe.sv
// +----------------------------------------------------------------------------+
// | gate_array_pipe                                                            |
// | Bitwise gate reduction over NUM_IN lanes feeding a 2-entry output buffer.  |
// | Optional statistics counters under macro GATE_STATS_EN.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gate_array_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2,
   parameter int CNT_W  = 16
) (
   input  wire              clk,
   input  wire              rst,
   gate_array_pipe_if.slave bus
`ifdef GATE_STATS_EN
   ,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] nor_zero_count
`endif
);

   localparam int ENTRY_W = WIDTH + 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [ENTRY_W-1:0] head;
   logic [ENTRY_W-1:0] tail;
   logic [WIDTH-1:0]   red_and;
   logic [WIDTH-1:0]   red_or;
   logic [WIDTH-1:0]   red_xor;
   logic [WIDTH-1:0]   result;
   logic               illegal;
   logic [ENTRY_W-1:0] entry;
   logic               accept;
   logic               pop;

   // in_ready is a pure decode of the state register, so out_ready never
   // reaches it combinationally.
   assign bus.in_ready  = (state != TWO);
   assign bus.out_valid = (state != EMPTY);
   assign bus.y         = head[WIDTH-1:0];
   assign bus.zero_flag = head[WIDTH];
   assign bus.err       = head[WIDTH+1];

   assign accept = bus.in_valid && bus.in_ready;
   assign pop    = bus.out_valid && bus.out_ready;

   always_comb begin
      red_and = bus.a_bus[WIDTH-1:0];
      red_or  = bus.a_bus[WIDTH-1:0];
      red_xor = bus.a_bus[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         red_and = red_and & bus.a_bus[k*WIDTH +: WIDTH];
         red_or  = red_or  | bus.a_bus[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ bus.a_bus[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (bus.mode)
         3'd0:    result = red_and;
         3'd1:    result = red_or;
         3'd2:    result = ~red_and;
         3'd3:    result = ~red_or;
         3'd4:    result = red_xor;
         3'd5:    result = ~red_xor;
         3'd6:    result = ~bus.a_bus[WIDTH-1:0];
         default: illegal = 1'b1;
      endcase
      entry = {illegal, (result == '0), result};
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (accept) state_next = ONE;
         ONE: begin
            if (accept && !pop)      state_next = TWO;
            else if (pop && !accept) state_next = EMPTY;
         end
         TWO:     if (pop) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         head  <= '0;
         tail  <= '0;
      end else begin
         state <= state_next;
         case (state)
            EMPTY: if (accept) head <= entry;
            ONE: begin
               if (accept && pop) head <= entry;
               else if (accept)   tail <= entry;
            end
            TWO:   if (pop) head <= tail;
            default: ;
         endcase
      end
   end

`ifdef GATE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count       <= '0;
         nor_zero_count <= '0;
      end else if (accept) begin
         if (op_count != {CNT_W{1'b1}})
            op_count <= op_count + 1'b1;
         if ((bus.mode == 3'd3) && (result == '0) &&
             (nor_zero_count != {CNT_W{1'b1}}))
            nor_zero_count <= nor_zero_count + 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, registered successor to the two-input NOR primitive.
- Applies one of several bitwise gate functions across NUM_IN operand lanes of WIDTH bits each.
- Results pass through a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between a producer of operand bundles and a consumer that may stall.

Parameters:
WIDTH, 8, bits per operand lane and per result.
NUM_IN, 2, number of operand lanes; legal range 2..8.
CNT_W, 16, width of the statistics counters (used only with GATE_STATS_EN).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand bundle, mode and op are valid this cycle.
in_ready  output  1  block can accept a bundle; registered (no combinational path from out_ready).
mode  input  3  gate select, sampled on accept.
a_bus  input  NUM_IN*WIDTH  operand lanes; lane k = a_bus[k*WIDTH +: WIDTH].
y  output  WIDTH  result at head of buffer.
out_valid  output  1  y, zero_flag and err are valid.
out_ready  input  1  consumer takes the head entry this cycle.
zero_flag  output  1  head result == 0.
err  output  1  head entry was computed with an illegal mode.
op_count  output  CNT_W  accepted-bundle count (GATE_STATS_EN only).
nor_zero_count  output  CNT_W  count of accepted NOR ops with all-zero result (GATE_STATS_EN only).

Behaviour:
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Mode encoding, reduced across all NUM_IN lanes bitwise:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT of lane 0 only; other lanes ignored.
  - 7 illegal: result 0, err=1 for that entry.
  - err=0 for modes 0..6.
- Result, zero_flag and err are computed combinationally at accept and stored together as one buffer entry of WIDTH+2 bits.
- Latency: a bundle accepted at edge t appears on y/out_valid after edge t, i.e. visible in cycle t+1.
- Buffer states are EMPTY, ONE and TWO; in_ready=1 in EMPTY and ONE, in_ready=0 in TWO.
  - EMPTY: accept -> ONE. No accept -> EMPTY.
  - ONE: accept and no pop -> TWO. Pop and no accept -> EMPTY. Accept and pop together -> ONE, with the new entry at the head next cycle.
  - TWO: pop -> ONE, second entry promoted to head. No pop -> TWO, head held stable.
- out_valid=1 in ONE and TWO; y, zero_flag and err always show the head entry.
- While out_valid=1 and out_ready=0, y, zero_flag and err must not change.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Reset: state=EMPTY, in_ready=1, out_valid=0, y=0, zero_flag=0, err=0, counters=0.
  - Reset mid-operation discards buffered entries.
  - An accept in the same cycle as rst is ignored.
- in_valid while in_ready=0 is held by the producer; the block takes no action.

Optional Feature:
- Macro GATE_STATS_EN.
- Defined:
  - op_count increments by 1 on every accept, including mode 7.
  - nor_zero_count increments on each accept with mode=3 and result==0.
  - Both counters saturate at all-ones, never wrap.
  - Both are cleared by rst.
- Undefined: op_count and nor_zero_count ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, NUM_IN=2, mode=3, lanes 0x0F and 0xF0, out_ready=1 -> y=0x00, zero_flag=1, err=0, out_valid one cycle after accept.
- NUM_IN=4, mode=4, lanes 0x01,0x02,0x04,0x08 -> y=0x0F. Same lanes with mode=5 -> y=0xF0.
- out_ready=0, three back-to-back bundles -> in_ready drops after 2 accepts. y holds the first result; then out_ready=1 drains both in order, with no loss or duplication.
- State ONE, simultaneous accept and pop for 10 cycles -> state stays ONE, in_ready stays 1, one result per cycle in order.
- mode=7, lanes 0xFF,0xFF -> y=0x00, err=1, zero_flag=1. Next bundle with mode=0 -> err=0, y=0xFF.
- GATE_STATS_EN, CNT_W=4, 20 NOR bundles of 0xFF,0x00 -> op_count saturates at 15 and nor_zero_count at 15. Reset asserted with two entries buffered -> out_valid=0, counters=0, next cycle in_ready=1.
